load_store_unit: RTL and testbench

- Multi-cycle memory-access stage that sits directly upstream of the load sign/zero-extension stage.
- Accepts one load or store request from the execute stage and runs a req/ready handshake with the 64-bit data memory.
- For loads, right-aligns the returned doubleword so the addressed byte sits at bit 0, ready for extension downstream.
- For stores, shifts write data into position and generates byte enables.
- Detects misaligned accesses, illegal widths and memory timeouts.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Opcodes, funct3 width codes, FSM states, latched request bundle.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    EXC
  } lsu_state_t;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
    logic [2:0] offset;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane formatting and legality for one access.
// Ports: store, funct3, offset in; be/wdata/ldata/legal/aligned out.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] sdata,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] ldata,
  output logic        legal,
  output logic        aligned
);

  logic [7:0] base;
  logic [5:0] sh;

  always_comb begin
    base    = 8'h00;
    aligned = 1'b0;
    sh      = {offset, 3'b000};
    unique case (funct3[1:0])
      2'b00: begin
        base    = 8'h01;
        aligned = 1'b1;
      end
      2'b01: begin
        base    = 8'h03;
        aligned = (offset[0] == 1'b0);
      end
      2'b10: begin
        base    = 8'h0f;
        aligned = (offset[1:0] == 2'b00);
      end
      2'b11: begin
        base    = 8'hff;
        aligned = (offset == 3'b000);
      end
    endcase
    // stores have no unsigned forms; loads lack a 111 code
    legal = store ? !funct3[2] : (funct3 != 3'b111);
    be    = store ? (base << offset) : 8'h00;
    wdata = store ? (sdata << sh) : 64'h0;
    ldata = rdata >> sh;
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage with req/ready memory handshake.
// Ports: start/opcode/funct3/address/storeData in; busy/done/flags, mem* bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT   = MAX_WAIT_DEF,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [63:0]           storeData,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           loadData,
  output logic                  misaligned,
  output logic                  accessFault,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [63:0]           memWriteData,
  output logic [7:0]            memByteEnable,
  input  logic                  memReady,
  input  logic [63:0]           memReadData
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  lsu_state_t state;
  lsu_req_t   req;
  logic [CW-1:0] cnt;

  logic is_ld;
  logic is_st;
  logic accept;
  logic a_store;
  logic [2:0] a_f3;
  logic [2:0] a_off;
  logic [7:0] be;
  logic [63:0] wdata;
  logic [63:0] ldata;
  logic legal;
  logic aligned;

  // In IDLE the aligner looks at the incoming request so legality
  // and store lanes are ready at acceptance; afterwards it uses the
  // latched request so the load shift matches the issued address.
  always_comb begin
    is_ld   = (opcode == OP_LOAD);
    is_st   = (opcode == OP_STORE);
    accept  = (state == IDLE) && start && (is_ld || is_st);
    a_store = req.store;
    a_f3    = req.funct3;
    a_off   = req.offset;
    if (state == IDLE) begin
      a_store = is_st;
      a_f3    = funct3;
      a_off   = address[2:0];
    end
  end

  lsu_align u_align (
    .store   (a_store),
    .funct3  (a_f3),
    .offset  (a_off),
    .sdata   (storeData),
    .rdata   (memReadData),
    .be      (be),
    .wdata   (wdata),
    .ldata   (ldata),
    .legal   (legal),
    .aligned (aligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req           <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      loadData      <= 64'h0;
      misaligned    <= 1'b0;
      accessFault   <= 1'b0;
      memAddr       <= '0;
      memRead       <= 1'b0;
      memWrite      <= 1'b0;
      memWriteData  <= 64'h0;
      memByteEnable <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req.store   <= is_st;
            req.funct3  <= funct3;
            req.offset  <= address[2:0];
            cnt         <= '0;
            busy        <= 1'b1;
            misaligned  <= 1'b0;
            accessFault <= 1'b0;
            if (!legal) begin
              accessFault <= 1'b1;
              done        <= 1'b1;
              state       <= EXC;
            end else if (!aligned) begin
              misaligned <= 1'b1;
              done       <= 1'b1;
              state      <= EXC;
            end else begin
              memAddr       <= {address[ADDR_WIDTH-1:3], 3'b000};
              memRead       <= is_ld;
              memWrite      <= is_st;
              memWriteData  <= wdata;
              memByteEnable <= be;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          // memReady wins over a timeout landing on the same edge
          if (memReady) begin
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            done     <= 1'b1;
            state    <= RESP;
            if (!req.store) begin
              loadData <= ldata;
            end
          end else if (cnt == LAST) begin
            memRead     <= 1'b0;
            memWrite    <= 1'b0;
            done        <= 1'b1;
            accessFault <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP, EXC: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] address;
  logic [63:0] storeData;
  logic        busy;
  logic        done;
  logic [63:0] loadData;
  logic        misaligned;
  logic        accessFault;
  logic [63:0] memAddr;
  logic        memRead;
  logic        memWrite;
  logic [63:0] memWriteData;
  logic [7:0]  memByteEnable;
  logic        memReady;
  logic [63:0] memReadData;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(16), .ADDR_WIDTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .opcode        (opcode),
    .funct3        (funct3),
    .address       (address),
    .storeData     (storeData),
    .busy          (busy),
    .done          (done),
    .loadData      (loadData),
    .misaligned    (misaligned),
    .accessFault   (accessFault),
    .memAddr       (memAddr),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .memWriteData  (memWriteData),
    .memByteEnable (memByteEnable),
    .memReady      (memReady),
    .memReadData   (memReadData)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] sd);
    opcode = op;
    funct3 = f3;
    address = a;
    storeData = sd;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    opcode = 7'h0;
    funct3 = 3'h0;
    address = 64'h0;
    storeData = 64'h0;
    memReady = 1'b0;
    memReadData = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, misaligned, accessFault, memRead, memWrite} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {busy, done, misaligned, accessFault, memRead, memWrite});
    end
    checks++;
    if (loadData !== 64'h0) begin
      failures++;
      $display("FAIL reset_loaddata got=%h exp=0", loadData);
    end
    checks++;
    if (memAddr !== 64'h0) begin
      failures++;
      $display("FAIL reset_memaddr got=%h exp=0", memAddr);
    end
    checks++;
    if (memWriteData !== 64'h0 || memByteEnable !== 8'h0) begin
      failures++;
      $display("FAIL reset_wbus got=%h/%h exp=0/0", memWriteData, memByteEnable);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ignored();
    opcode = 7'b0110011;
    start = 1'b1;
    memReady = 1'b1;
    step();
    start = 1'b0;
    memReady = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || memRead !== 1'b0) begin
      failures++;
      $display("FAIL ignored_op got=busy%b done%b rd%b exp=000", busy, done, memRead);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignored_op2 got=busy%b done%b exp=00", busy, done);
    end
  endtask

  task automatic test_lw();
    int reads;
    reads = 0;
    issue(LD, 3'b010, 64'h1004, 64'h0);
    checks++;
    if (memAddr !== 64'h1000 || memByteEnable !== 8'h00) begin
      failures++;
      $display("FAIL lw_addr got=%h/%h exp=1000/00", memAddr, memByteEnable);
    end
    for (int i = 0; i < 3; i++) begin
      if (memRead === 1'b1) reads++;
      if (i == 2) begin
        memReady = 1'b1;
        memReadData = 64'h89ABCDEF_01234567;
      end
      step();
    end
    memReady = 1'b0;
    checks++;
    if (reads != 3 || memRead !== 1'b0) begin
      failures++;
      $display("FAIL lw_reads got=%0d rd%b exp=3 rd0", reads, memRead);
    end
    checks++;
    if (done !== 1'b1 || loadData !== 64'h00000000_89ABCDEF) begin
      failures++;
      $display("FAIL lw_data got=done%b %h exp=done1 0000000089abcdef", done, loadData);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL lw_end got=done%b busy%b exp=00", done, busy);
    end
  endtask

  task automatic test_sb();
    issue(ST, 3'b000, 64'h2003, 64'hAA);
    checks++;
    if (memWrite !== 1'b1 || memRead !== 1'b0 || memAddr !== 64'h2000) begin
      failures++;
      $display("FAIL sb_req got=wr%b rd%b %h exp=wr1 rd0 2000", memWrite, memRead, memAddr);
    end
    checks++;
    if (memByteEnable !== 8'h08 || memWriteData !== 64'h00000000_AA000000) begin
      failures++;
      $display("FAIL sb_lanes got=%h/%h exp=08/00000000aa000000",
               memByteEnable, memWriteData);
    end
    step();
    checks++;
    if (memWrite !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL sb_hold got=wr%b done%b exp=wr1 done0", memWrite, done);
    end
    memReady = 1'b1;
    memReadData = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    memReady = 1'b0;
    checks++;
    if (done !== 1'b1 || memWrite !== 1'b0 || loadData !== 64'h89ABCDEF) begin
      failures++;
      $display("FAIL sb_done got=done%b wr%b %h exp=done1 wr0 89abcdef",
               done, memWrite, loadData);
    end
    step();
    issue(ST, 3'b001, 64'h2006, 64'hBEEF);
    checks++;
    if (memByteEnable !== 8'hC0 || memWriteData !== 64'hBEEF0000_00000000) begin
      failures++;
      $display("FAIL sh_lanes got=%h/%h exp=c0/beef000000000000",
               memByteEnable, memWriteData);
    end
    memReady = 1'b1;
    step();
    memReady = 1'b0;
    step();
  endtask

  task automatic test_exc();
    issue(LD, 3'b001, 64'h1001, 64'h0);
    checks++;
    if (done !== 1'b1 || misaligned !== 1'b1 || accessFault !== 1'b0 || memRead !== 1'b0) begin
      failures++;
      $display("FAIL lh_misal got=done%b mis%b af%b rd%b exp=1100",
               done, misaligned, accessFault, memRead);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || misaligned !== 1'b1) begin
      failures++;
      $display("FAIL lh_hold got=done%b busy%b mis%b exp=001", done, busy, misaligned);
    end
    issue(LD, 3'b111, 64'h1000, 64'h0);
    checks++;
    if (done !== 1'b1 || accessFault !== 1'b1 || misaligned !== 1'b0 || memRead !== 1'b0) begin
      failures++;
      $display("FAIL ld111 got=done%b af%b mis%b rd%b exp=1100",
               done, accessFault, misaligned, memRead);
    end
    step();
    issue(ST, 3'b100, 64'h2000, 64'h0);
    checks++;
    if (done !== 1'b1 || accessFault !== 1'b1 || memWrite !== 1'b0) begin
      failures++;
      $display("FAIL st100 got=done%b af%b wr%b exp=110", done, accessFault, memWrite);
    end
    step();
    issue(ST, 3'b010, 64'h2002, 64'h0);
    checks++;
    if (done !== 1'b1 || misaligned !== 1'b1 || accessFault !== 1'b0 || memWrite !== 1'b0) begin
      failures++;
      $display("FAIL sw_misal got=done%b mis%b af%b wr%b exp=1100",
               done, misaligned, accessFault, memWrite);
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    issue(LD, 3'b011, 64'h3000, 64'h0);
    while (memRead === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL to_cycles got=%0d exp=16", n);
    end
    checks++;
    if (done !== 1'b1 || accessFault !== 1'b1 || loadData !== 64'h89ABCDEF) begin
      failures++;
      $display("FAIL to_done got=done%b af%b %h exp=done1 af1 89abcdef",
               done, accessFault, loadData);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || accessFault !== 1'b1) begin
      failures++;
      $display("FAIL to_end got=busy%b done%b af%b exp=001", busy, done, accessFault);
    end
  endtask

  task automatic test_timeout_edge();
    issue(LD, 3'b011, 64'h3008, 64'h0);
    repeat (15) step();
    checks++;
    if (memRead !== 1'b1 || accessFault !== 1'b0) begin
      failures++;
      $display("FAIL toe_last got=rd%b af%b exp=rd1 af0", memRead, accessFault);
    end
    memReady = 1'b1;
    memReadData = 64'h11223344_55667788;
    step();
    memReady = 1'b0;
    checks++;
    if (done !== 1'b1 || accessFault !== 1'b0 || loadData !== 64'h11223344_55667788) begin
      failures++;
      $display("FAIL toe_win got=done%b af%b %h exp=done1 af0 1122334455667788",
               done, accessFault, loadData);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    issue(LD, 3'b011, 64'h5000, 64'h0);
    address = 64'h6000;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (memAddr !== 64'h5000 || memRead !== 1'b1) begin
      failures++;
      $display("FAIL b2b_addr got=%h rd%b exp=5000 rd1", memAddr, memRead);
    end
    memReady = 1'b1;
    memReadData = 64'h0123;
    for (int i = 0; i < 6; i++) begin
      step();
      memReady = 1'b0;
      if (done === 1'b1) n++;
    end
    checks++;
    if (n != 1 || busy !== 1'b0 || loadData !== 64'h0123) begin
      failures++;
      $display("FAIL b2b_done got=%0d busy%b %h exp=1 busy0 0123", n, busy, loadData);
    end
  endtask

  task automatic test_reset_mid();
    issue(LD, 3'b000, 64'h40, 64'h0);
    checks++;
    if (memRead !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_pre got=rd%b busy%b exp=11", memRead, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (memRead !== 1'b0 || busy !== 1'b0 || loadData !== 64'h0 || memAddr !== 64'h0) begin
      failures++;
      $display("FAIL rm_async got=rd%b busy%b %h %h exp=rd0 busy0 0 0",
               memRead, busy, loadData, memAddr);
    end
    step();
    reset = 1'b0;
    step();
    issue(LD, 3'b000, 64'h7, 64'h0);
    checks++;
    if (memRead !== 1'b1 || memAddr !== 64'h0) begin
      failures++;
      $display("FAIL rm_lb_req got=rd%b %h exp=rd1 0", memRead, memAddr);
    end
    memReady = 1'b1;
    memReadData = 64'h80000000_00000000;
    step();
    memReady = 1'b0;
    checks++;
    if (done !== 1'b1 || loadData !== 64'h80) begin
      failures++;
      $display("FAIL rm_lb got=done%b %h exp=done1 80", done, loadData);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ignored();
    test_lw();
    test_sb();
    test_exc();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
